// File: rtl/nc_timing_seq.sv
// Memory-cycle sequencer ahead of NC: accept CPU/panel access, emit ordered strobes, return read data.
// Latency: ack to done is T_ACC+3 cycles; requests are levels held until ack, never acked during Z0NC or mid-access.
module nc_timing_seq #(
    parameter int AW    = 15,
    parameter int DW    = 16,
    parameter int T_ACC = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pnl_req,
    input  logic          i_pnl_wr,
    input  logic [AW-1:0] i_pnl_addr,
    input  logic [DW-1:0] i_pnl_wdata,
    input  logic          i_clr,
    input  logic [DW-1:0] i_NCSC,
    input  logic          i_Cjyc,
    output logic          o_ack,
    output logic          o_pnl_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_rdata,
    output logic          o_err,
    output logic [15:0]   o_NCDZ,
    output logic [DW-1:0] o_NCSR,
    output logic          o_W1,
    output logic          o_XT,
    output logic          o_XL,
    output logic          o_DL1,
    output logic          o_DL2,
    output logic          o_SZMNC,
    output logic          o_Z0NC
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEL,
        ST_WAIT,
        ST_END,
        ST_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'((T_ACC > 1) ? (T_ACC - 2) : 0);

    state_t        st;
    state_t        nxt;
    logic [3:0]    wait_cnt;
    logic [1:0]    z0_cnt;
    logic          lat_wr;
    logic          lat_pnl;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    logic          take_cpu;
    logic          take_pnl;
    logic          d_xt;
    logic          d_xl;
    logic          d_dl1;
    logic          d_dl2;
    logic          d_szmnc;

    // Accepts are held off until the Z0NC window has fully drained, so an ack never overlaps Z0NC.
    assign take_cpu = (st == ST_IDLE) && (z0_cnt == 2'd0) && !i_clr && i_req;
    assign take_pnl = (st == ST_IDLE) && (z0_cnt == 2'd0) && !i_clr && !i_req && i_pnl_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st <= ST_IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt     = st;
        d_xt    = 1'b0;
        d_xl    = 1'b0;
        d_dl1   = 1'b0;
        d_dl2   = 1'b0;
        d_szmnc = 1'b0;
        case (st)
            ST_IDLE: begin
                if (take_cpu || take_pnl) begin
                    nxt = ST_SETUP;
                end
            end
            ST_SETUP: nxt = ST_SEL;
            ST_SEL: begin
                d_dl1 = lat_pnl;
                d_xl  = !lat_pnl && lat_wr;
                d_xt  = !lat_pnl && !lat_wr;
                nxt   = (T_ACC == 1) ? ST_END : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    nxt = ST_END;
                end
            end
            ST_END: begin
                d_dl2   = lat_pnl;
                d_szmnc = !lat_pnl;
                nxt     = ST_DONE;
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
        if (i_clr) begin
            nxt     = ST_IDLE;
            d_xt    = 1'b0;
            d_xl    = 1'b0;
            d_dl1   = 1'b0;
            d_dl2   = 1'b0;
            d_szmnc = 1'b0;
        end
    end

    // Each state's outputs are registered on the edge that leaves it, so they appear one cycle behind st.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ack     <= 1'b0;
            o_pnl_ack <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            o_NCDZ    <= '0;
            o_NCSR    <= '0;
            o_W1      <= 1'b0;
            o_XT      <= 1'b0;
            o_XL      <= 1'b0;
            o_DL1     <= 1'b0;
            o_DL2     <= 1'b0;
            o_SZMNC   <= 1'b0;
            o_Z0NC    <= 1'b1;
            z0_cnt    <= 2'd2;
            wait_cnt  <= '0;
            lat_wr    <= 1'b0;
            lat_pnl   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            o_ack     <= take_cpu;
            o_pnl_ack <= take_pnl;
            o_done    <= 1'b0;
            o_XT      <= d_xt;
            o_XL      <= d_xl;
            o_DL1     <= d_dl1;
            o_DL2     <= d_dl2;
            o_SZMNC   <= d_szmnc;
            o_busy    <= (nxt != ST_IDLE) || ((st == ST_DONE) && !i_clr);
            o_Z0NC    <= i_clr || (z0_cnt != 2'd0);

            if (i_clr) begin
                z0_cnt <= 2'd0;
            end else if (z0_cnt != 2'd0) begin
                z0_cnt <= z0_cnt - 2'd1;
            end

            if (take_cpu) begin
                lat_wr    <= i_wr;
                lat_pnl   <= 1'b0;
                lat_addr  <= i_addr;
                lat_wdata <= i_wdata;
            end else if (take_pnl) begin
                lat_wr    <= i_pnl_wr;
                lat_pnl   <= 1'b1;
                lat_addr  <= i_pnl_addr;
                lat_wdata <= i_pnl_wdata;
            end

            if (st == ST_SEL) begin
                wait_cnt <= WAIT_INIT;
            end else if ((st == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (i_clr) begin
                o_W1 <= 1'b0;
            end else begin
                case (st)
                    ST_SETUP: begin
                        o_NCDZ <= 16'(lat_addr);
                        o_NCSR <= lat_wdata;
                        o_W1   <= lat_wr;
                    end
                    ST_DONE: begin
                        o_W1   <= 1'b0;
                        o_done <= 1'b1;
                        o_err  <= lat_pnl ? 1'b0 : i_Cjyc;
                        if (!lat_wr) begin
                            o_rdata <= i_NCSC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nc_timing_seq.sv
// Directed bench for nc_timing_seq: table of accesses plus reset, arbitration, clear and mid-access reset sequences.
module tb_nc_timing_seq;

    localparam int TACC = 3;

    typedef struct {
        logic        pnl;
        logic        wr;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] ncsc;
        logic        cjyc;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [14:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        pnl_req = 1'b0;
    logic        pnl_wr = 1'b0;
    logic [14:0] pnl_addr = '0;
    logic [15:0] pnl_wdata = '0;
    logic        clr = 1'b0;
    logic [15:0] ncsc = '0;
    logic        cjyc = 1'b0;
    logic        ack, pnl_ack, busy, done, err;
    logic [15:0] rdata, ncdz, ncsr;
    logic        w1, xt, xl, dl1, dl2, szmnc, z0;

    int n_run = 0;
    int n_fail = 0;

    nc_timing_seq #(.AW(15), .DW(16), .T_ACC(TACC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req(req), .i_wr(wr), .i_addr(addr), .i_wdata(wdata),
        .i_pnl_req(pnl_req), .i_pnl_wr(pnl_wr), .i_pnl_addr(pnl_addr), .i_pnl_wdata(pnl_wdata),
        .i_clr(clr), .i_NCSC(ncsc), .i_Cjyc(cjyc),
        .o_ack(ack), .o_pnl_ack(pnl_ack), .o_busy(busy), .o_done(done),
        .o_rdata(rdata), .o_err(err), .o_NCDZ(ncdz), .o_NCSR(ncsr), .o_W1(w1),
        .o_XT(xt), .o_XL(xl), .o_DL1(dl1), .o_DL2(dl2), .o_SZMNC(szmnc), .o_Z0NC(z0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if (v.pnl) begin
            pnl_req = 1'b1; pnl_wr = v.wr; pnl_addr = v.addr; pnl_wdata = v.wdata;
        end else begin
            req = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wdata;
        end
    endtask

    // Steps until the matching ack shows; exp_steps > 0 also pins the request-to-ack spacing.
    task automatic wait_ack(input vec_t v, input int exp_steps);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            got = v.pnl ? pnl_ack : ack;
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (exp_steps > 0) chk("ack_spacing", n, exp_steps);
    endtask

    // Entered in the ack cycle; checks every cycle up to and including the done cycle.
    task automatic follow(input vec_t v);
        logic [6:0] exp_v;
        logic [6:0] act_v;
        ncsc = v.ncsc;
        cjyc = v.cjyc;
        if (v.pnl) pnl_req = 1'b0; else req = 1'b0;
        for (int r = 1; r <= TACC + 3; r++) begin
            step();
            exp_v    = '0;
            exp_v[6] = v.wr && (r <= TACC + 2);
            exp_v[5] = !v.pnl && !v.wr && (r == 2);
            exp_v[4] = !v.pnl && v.wr && (r == 2);
            exp_v[3] = v.pnl && (r == 2);
            exp_v[2] = v.pnl && (r == TACC + 2);
            exp_v[1] = !v.pnl && (r == TACC + 2);
            exp_v[0] = (r == TACC + 3);
            act_v = {w1, xt, xl, dl1, dl2, szmnc, done};
            chk($sformatf("w1_xt_xl_dl1_dl2_szm_done@%0d", r), act_v, exp_v);
            if (r == 1) begin
                chk("ncdz", ncdz, {1'b0, v.addr});
                chk("ncsr", ncsr, v.wdata);
            end
        end
        chk("rdata", rdata, v.exp_rdata);
        chk("err", err, v.exp_err);
        chk("busy_at_done", busy, 1);
    endtask

    // Entered with rst high; releases it and checks the Z0NC window and the held request.
    task automatic rst_release(input vec_t v);
        drive(v);
        chk("z0_in_reset", z0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("z0_after_fall", z0, 1);
        step();
        chk("z0_cyc1", {z0, ack, xt, w1}, 4'b1000);
        step();
        chk("z0_cyc2", {z0, ack, xt, w1}, 4'b1000);
        step();
        chk("z0_cyc3_ack", {z0, ack, busy}, 3'b011);
        follow(v);
    endtask

    vec_t tbl[5];
    vec_t va, vc, vp, vw, vq, vr_w, vr;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 15'h1234, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 15'h7FFF, 16'h5A5A, 16'h1111, 1'b1, 16'hBEEF, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 15'h0042, 16'h0F0F, 16'hC0DE, 1'b1, 16'hC0DE, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 15'h2000, 16'hA5A5, 16'h2222, 1'b1, 16'hC0DE, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 15'h0000, 16'h7777, 16'h0001, 1'b1, 16'h0001, 1'b1};
        va   = '{1'b0, 1'b0, 15'h0100, 16'h0000, 16'h00FF, 1'b0, 16'h00FF, 1'b0};
        vc   = '{1'b0, 1'b0, 15'h0ABC, 16'h0000, 16'h1357, 1'b0, 16'h1357, 1'b0};
        vp   = '{1'b1, 1'b0, 15'h0055, 16'h0000, 16'h2468, 1'b1, 16'h2468, 1'b0};
        vw   = '{1'b0, 1'b1, 15'h0300, 16'h1111, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vq   = '{1'b1, 1'b0, 15'h0066, 16'h0000, 16'h3C3C, 1'b1, 16'h3C3C, 1'b0};
        vr_w = '{1'b0, 1'b1, 15'h0404, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vr   = '{1'b0, 1'b0, 15'h0777, 16'h0000, 16'h8001, 1'b0, 16'h8001, 1'b0};

        #1;
        chk("reset_outs", {ack, pnl_ack, busy, done, err, w1, xt, xl, dl1, dl2, szmnc}, 0);
        chk("reset_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        rst_release(va);

        // Back-to-back accesses, each raised in the previous done cycle.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            wait_ack(tbl[i], 1);
            follow(tbl[i]);
        end

        // Simultaneous requests: CPU first, panel right after CPU done.
        drive(vc);
        drive(vp);
        wait_ack(vc, 1);
        chk("pnl_ack_blocked", pnl_ack, 0);
        follow(vc);
        wait_ack(vp, 1);
        follow(vp);
        step();
        chk("idle_after", {busy, done, ack, pnl_ack}, 0);

        // Clear during WAIT of a write, with a panel request raised alongside.
        drive(vw);
        wait_ack(vw, 0);
        req = 1'b0;
        repeat (3) step();
        chk("w1_in_wait", w1, 1);
        clr = 1'b1;
        drive(vq);
        step();
        clr = 1'b0;
        chk("clr_outs", {z0, w1, xt, xl, dl1, dl2, szmnc, done, busy, pnl_ack}, 10'b10_0000_0000);
        step();
        chk("clr_release", {z0, pnl_ack, done}, 3'b010);
        follow(vq);

        // Asynchronous reset during WAIT of a write, then a clean read.
        drive(vr_w);
        wait_ack(vr_w, 1);
        req = 1'b0;
        repeat (3) step();
        chk("w1_before_rst", w1, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_outs", {w1, xt, xl, dl1, dl2, szmnc, done, busy, ack, pnl_ack, err}, 0);
        chk("rst_async_ncdz", ncdz, 0);
        chk("rst_async_ncsr", ncsr, 0);
        chk("rst_async_rdata", rdata, 0);
        chk("rst_async_z0", z0, 1);
        rst_release(vr);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/nc_timing_seq.md
Name: nc_timing_seq

Overview:
Memory-cycle timing sequencer that sits directly upstream of the NC memory stage. It accepts CPU and front-panel read/write requests, registers the address and write data, and generates the ordered strobes NC consumes: DL1/DL2 for panel cycles, XT/XL for CPU cycles, and W1, SZMNC and Z0NC. It captures NC's read data and parity-check result and returns them to the requester with a done pulse.

Parameters:
AW, 15, address width (matches NC memory address).
DW, 16, data width.
T_ACC, 3, clock cycles from the select strobe (XT/XL/DL1) to the SZMNC/DL2 strobe, range 1..15.

Ports:
i_clk  in  1  system clock; all outputs registered on its rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_req  in  1  CPU access request; level, held until o_ack.
i_wr  in  1  CPU access type: 1 = write, 0 = read; sampled with i_req.
i_addr  in  AW  CPU address.
i_wdata  in  DW  CPU write data.
i_pnl_req  in  1  front-panel access request; level, held until o_pnl_ack.
i_pnl_wr  in  1  panel access type.
i_pnl_addr  in  AW  panel address.
i_pnl_wdata  in  DW  panel write data.
i_clr  in  1  memory-interface clear request (single-cycle pulse).
i_NCSC  in  DW  read data from NC.
i_Cjyc  in  1  parity-check result from NC.
o_ack  out  1  1-cycle pulse: CPU request accepted.
o_pnl_ack  out  1  1-cycle pulse: panel request accepted.
o_busy  out  1  high from the accept cycle until the o_done cycle, inclusive.
o_done  out  1  1-cycle pulse: access complete.
o_rdata  out  DW  captured read data; holds until the next read completes.
o_err  out  1  parity error for the completed access; valid with o_done.
o_NCDZ  out  16  address to NC; bit 15 = 0.
o_NCSR  out  DW  write data to NC.
o_W1  out  1  write enable to NC.
o_XT  out  1  CPU read select strobe.
o_XL  out  1  CPU write select strobe.
o_DL1  out  1  panel select strobe.
o_DL2  out  1  panel cycle end strobe.
o_SZMNC  out  1  CPU cycle end / check-capture strobe.
o_Z0NC  out  1  NC clear.

Behaviour:
- Reset: all outputs 0, o_rdata 0, state IDLE. Reset mid-cycle aborts the access with no o_done.
- Z0NC sequencing: o_Z0NC is 1 during reset and for 2 cycles after i_rst falls. No request is accepted while o_Z0NC = 1.
- States: IDLE, SETUP, SEL, WAIT, END, DONE.
- IDLE:
  - If i_req: pulse o_ack, latch i_wr/i_addr/i_wdata, set src = CPU, go to SETUP.
  - Else if i_pnl_req: same, using the panel inputs; pulse o_pnl_ack; set src = PNL.
  - CPU has priority when both requests are high.
- SETUP (1 cycle): o_NCDZ and o_NCSR are driven from the latched values. o_W1 = wr. o_W1 stays high through END and drops in DONE.
- SEL (1 cycle): assert exactly one strobe: o_DL1 if src = PNL; else o_XL if wr, else o_XT.
- WAIT: lasts T_ACC-1 cycles; skipped when T_ACC = 1.
- END (1 cycle): o_DL2 if src = PNL, else o_SZMNC. The END-cycle strobe rises exactly T_ACC cycles after the SEL strobe rises.
- DONE (1 cycle):
  - Pulse o_done.
  - o_err = i_Cjyc for CPU cycles; o_err = 0 for panel cycles.
  - If the access was a read, latch o_rdata from i_NCSC.
  - Return to IDLE. The next accept is possible in the following cycle, so the minimum request-to-request spacing is T_ACC + 4 cycles.
- o_NCDZ and o_NCSR hold their values after DONE until the next SETUP.
- o_err holds until the next o_done.
- i_clr in any state: o_Z0NC = 1 for 1 cycle, all strobes and o_W1 drop, state goes to IDLE, no o_done.
  - A request pending during the clear is not acked until the cycle after o_Z0NC falls.
- Strobes are mutually exclusive; at most one of XT/XL/DL1/DL2/SZMNC is high in any cycle.

Test Plan:
- Reset release: o_Z0NC high for 2 cycles after i_rst falls; i_req held from reset gets o_ack only on the 3rd cycle after i_rst falls; all strobes 0 until then.
- CPU read, addr 0x1234, T_ACC = 3, i_NCSC = 0xBEEF, i_Cjyc = 0 -> o_ack at t0; XT at t0+2; SZMNC at t0+5; o_done at t0+6 with o_rdata = 0xBEEF and o_err = 0; o_W1 never high.
- CPU write, addr 0x7FFF, data 0x5A5A, i_Cjyc = 1 -> o_NCDZ = 0x7FFF; o_W1 high t0+1..t0+5; XL at t0+2; o_done at t0+6 with o_err = 1; o_rdata unchanged.
- Simultaneous i_req and i_pnl_req -> CPU acked first. Panel acked in the cycle after the CPU o_done; uses DL1/DL2 only (no XT/XL/SZMNC); its o_done has o_err = 0.
- i_clr pulsed in the WAIT state -> o_Z0NC for 1 cycle, strobes and W1 drop, no o_done, o_busy = 0 on the next cycle.
- i_rst asserted during WAIT of a write -> all outputs 0 immediately and asynchronously; after release, the Z0NC sequence repeats and a new read completes normally.
